// File: rtl/pixel_writer_pkg.sv
// Shared types and widths for the RGB byte-stream to 12-bit pixel writer.
package pixel_writer_pkg;

    localparam int CHAN_IN_W  = 8;
    localparam int CHAN_OUT_W = 4;
    localparam int PIX_W      = 3 * CHAN_OUT_W;

    // Receive FSM encoding; wire byte order is R, G, B, then one write cycle.
    typedef logic [1:0] state_t;
    localparam state_t S_R     = 2'd0;
    localparam state_t S_G     = 2'd1;
    localparam state_t S_B     = 2'd2;
    localparam state_t S_WRITE = 2'd3;

endpackage

// File: rtl/channel_quantizer.sv
// 8-bit colour channel to 4-bit nibble. Define PIXEL_ROUND_EN for
// round-to-nearest with saturation; otherwise the upper nibble is kept.
module channel_quantizer
    import pixel_writer_pkg::*;
(
    input  logic [CHAN_IN_W-1:0]  chan_i,
    output logic [CHAN_OUT_W-1:0] nib_o
);

`ifdef PIXEL_ROUND_EN
    logic [CHAN_IN_W:0] sum;

    // Bytes 248..255 round up to 16, which does not fit a nibble: clamp to 15.
    assign sum   = {1'b0, chan_i} + (CHAN_IN_W + 1)'(8);
    assign nib_o = sum[CHAN_IN_W] ? {CHAN_OUT_W{1'b1}} : sum[CHAN_IN_W-1 -: CHAN_OUT_W];
`else
    logic unused_low_bits;

    assign nib_o           = chan_i[CHAN_IN_W-1 -: CHAN_OUT_W];
    assign unused_low_bits = ^chan_i[CHAN_IN_W-CHAN_OUT_W-1:0];
`endif

endmodule

// File: rtl/pixel_writer_12bit.sv
// Packs R, G, B bytes into {B,G,R} 12-bit pixels and writes them to a frame
// buffer in raster order. Quantisation mode follows macro PIXEL_ROUND_EN.
module pixel_writer_12bit
    import pixel_writer_pkg::*;
#(
    parameter int NUM_PIXELS = 49152,
    parameter int ADDR_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CHAN_IN_W-1:0] rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    input  logic                 sync_clear,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [PIX_W-1:0]     wr_data,
    output logic                 frame_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    state_t                state_q, state_d;
    logic [CHAN_OUT_W-1:0] r_q, r_d;
    logic [CHAN_OUT_W-1:0] g_q, g_d;
    logic [CHAN_OUT_W-1:0] b_q, b_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [PIX_W-1:0]      data_q, data_d;
    logic [CHAN_OUT_W-1:0] nib;
    logic                  accept;
    logic [PIX_W-1:0]      pixel;

    // One quantizer serves all channels: only one byte is accepted per cycle.
    channel_quantizer u_quant (
        .chan_i (rx_data),
        .nib_o  (nib)
    );

    assign rx_ready   = !rst && !sync_clear && (state_q != S_WRITE);
    assign accept     = rx_valid && rx_ready;
    assign wr_en      = !rst && !sync_clear && (state_q == S_WRITE);
    assign frame_done = wr_en && (addr_q == LAST_ADDR);
    assign wr_addr    = addr_q;
    assign pixel      = {b_q, g_q, r_q};

    // Live pixel while writing; afterwards the last written pixel is held.
    assign wr_data = (state_q == S_WRITE) ? pixel : data_q;

    // NOTE: every next-state variable gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (sync_clear) begin
            state_d = S_R;
            addr_d  = '0;
        end else begin
            case (state_q)
                S_R: if (accept) begin
                    r_d     = nib;
                    state_d = S_G;
                end
                S_G: if (accept) begin
                    g_d     = nib;
                    state_d = S_B;
                end
                S_B: if (accept) begin
                    b_d     = nib;
                    state_d = S_WRITE;
                end
                default: begin
                    state_d = S_R;
                    data_d  = pixel;
                    addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_R;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_pixel_writer_12bit.sv
// Directed bench for pixel_writer_12bit (NUM_PIXELS=4); expectations follow
// PIXEL_ROUND_EN when it is defined.
module tb_pixel_writer_12bit;

    localparam int NP = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          sync_clear = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;
    logic          frame_done;

    int vectors     = 0;
    int miscompares = 0;

    pixel_writer_12bit #(.NUM_PIXELS(NP), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .sync_clear (sync_clear),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after the edge; outputs are sampled 1 ns later.
    task automatic step(input logic v, input logic [7:0] d, input logic c);
        @(posedge clk);
        #1;
        rx_valid   = v;
        rx_data    = d;
        sync_clear = c;
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; rx_valid = 1'b0; sync_clear = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        vectors++; if (rx_ready !== 1'b0) begin miscompares++; $display("FAIL rst_rx_ready: got %b want 0", rx_ready); end
        vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
        vectors++; if (wr_addr !== 3'd0) begin miscompares++; $display("FAIL rst_wr_addr: got %0d want 0", wr_addr); end
        vectors++; if (wr_data !== 12'h000) begin miscompares++; $display("FAIL rst_wr_data: got %h want 000", wr_data); end
        rst = 1'b0;
        #1;
        vectors++; if (rx_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready: got %b want 1", rx_ready); end
    endtask

    task automatic test_basic();
        logic [11:0] exp;
`ifdef PIXEL_ROUND_EN
        exp = 12'h28F;
`else
        exp = 12'h18F;
`endif
        do_reset();
        step(1'b1, 8'hF0, 1'b0);
        vectors++; if (rx_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready_r: got %b want 1", rx_ready); end
        step(1'b1, 8'h80, 1'b0);
        step(1'b1, 8'h1F, 1'b0);
        vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL basic_early_wr: got %b want 0", wr_en); end
        step(1'b1, 8'hAA, 1'b0);
        vectors++; if (wr_en !== 1'b1) begin miscompares++; $display("FAIL basic_wr_en: got %b want 1", wr_en); end
        vectors++; if (rx_ready !== 1'b0) begin miscompares++; $display("FAIL basic_ready_wr: got %b want 0", rx_ready); end
        vectors++; if (wr_addr !== 3'd0) begin miscompares++; $display("FAIL basic_addr: got %0d want 0", wr_addr); end
        vectors++; if (wr_data !== exp) begin miscompares++; $display("FAIL basic_data: got %h want %h", wr_data, exp); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL basic_frame_done: got %b want 0", frame_done); end
        step(1'b0, 8'h00, 1'b0);
        vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL basic_single_wr: got %b want 0", wr_en); end
        vectors++; if (wr_addr !== 3'd1) begin miscompares++; $display("FAIL basic_addr_inc: got %0d want 1", wr_addr); end
        vectors++; if (wr_data !== exp) begin miscompares++; $display("FAIL basic_data_hold: got %h want %h", wr_data, exp); end
    endtask

    task automatic test_saturate();
        do_reset();
        step(1'b1, 8'hFF, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        vectors++; if (wr_en !== 1'b1) begin miscompares++; $display("FAIL sat_wr_en: got %b want 1", wr_en); end
        vectors++; if (wr_data !== 12'hFFF) begin miscompares++; $display("FAIL sat_data: got %h want FFF", wr_data); end
    endtask

    task automatic test_gaps();
        logic [7:0]  bytes [3];
        logic [11:0] exp;
`ifdef PIXEL_ROUND_EN
        exp = 12'hA64;
`else
        exp = 12'hA53;
`endif
        bytes[0] = 8'h3C; bytes[1] = 8'h5A; bytes[2] = 8'hA5;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, bytes[k], 1'b0);
            for (int g = 0; g < 5; g++) begin
                step(1'b0, 8'h00, 1'b0);
                if (k == 2 && g == 0) begin
                    vectors++; if (wr_en !== 1'b1) begin miscompares++; $display("FAIL gap_wr_en: got %b want 1", wr_en); end
                    vectors++; if (rx_ready !== 1'b0) begin miscompares++; $display("FAIL gap_ready_wr: got %b want 0", rx_ready); end
                    vectors++; if (wr_data !== exp) begin miscompares++; $display("FAIL gap_data: got %h want %h", wr_data, exp); end
                end else begin
                    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL gap_idle_wr byte %0d gap %0d: got %b want 0", k, g, wr_en); end
                    vectors++; if (rx_ready !== 1'b1) begin miscompares++; $display("FAIL gap_idle_ready byte %0d gap %0d: got %b want 1", k, g, rx_ready); end
                end
            end
        end
    endtask

    task automatic test_frame_wrap();
        logic [11:0] exp;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            // Each byte 16*n quantizes to n under both truncation and rounding.
            exp = {4'(i + 2), 4'(i + 1), 4'(i)};
            step(1'b1, 8'(16 * i), 1'b0);
            step(1'b1, 8'(16 * (i + 1)), 1'b0);
            step(1'b1, 8'(16 * (i + 2)), 1'b0);
            step(1'b1, 8'h00, 1'b0);
            vectors++; if (wr_en !== 1'b1) begin miscompares++; $display("FAIL wrap_wr_en px %0d: got %b want 1", i, wr_en); end
            vectors++; if (wr_addr !== 3'(i % NP)) begin miscompares++; $display("FAIL wrap_addr px %0d: got %0d want %0d", i, wr_addr, i % NP); end
            vectors++; if (frame_done !== (i == 3)) begin miscompares++; $display("FAIL wrap_frame_done px %0d: got %b want %b", i, frame_done, (i == 3)); end
            vectors++; if (wr_data !== exp) begin miscompares++; $display("FAIL wrap_data px %0d: got %h want %h", i, wr_data, exp); end
        end
    endtask

    task automatic test_sync_clear();
        do_reset();
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b1);
        vectors++; if (rx_ready !== 1'b0) begin miscompares++; $display("FAIL clr_ready: got %b want 0", rx_ready); end
        vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL clr_wr_en: got %b want 0", wr_en); end
        step(1'b1, 8'h44, 1'b0);
        vectors++; if (wr_addr !== 3'd0) begin miscompares++; $display("FAIL clr_addr_zero: got %0d want 0", wr_addr); end
        step(1'b1, 8'h55, 1'b0);
        step(1'b1, 8'h66, 1'b0);
        vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL clr_no_wr: got %b want 0", wr_en); end
        step(1'b0, 8'h00, 1'b0);
        vectors++; if (wr_en !== 1'b1) begin miscompares++; $display("FAIL clr_wr_after: got %b want 1", wr_en); end
        vectors++; if (wr_addr !== 3'd0) begin miscompares++; $display("FAIL clr_wr_addr: got %0d want 0", wr_addr); end
        vectors++; if (wr_data !== 12'h654) begin miscompares++; $display("FAIL clr_wr_data: got %h want 654", wr_data); end
    endtask

    task automatic test_reset_in_write();
        do_reset();
        step(1'b1, 8'h12, 1'b0);
        step(1'b1, 8'h34, 1'b0);
        step(1'b1, 8'h56, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h9A, 1'b0);
        step(1'b1, 8'hBC, 1'b0);
        step(1'b1, 8'hDE, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1; rx_valid = 1'b0;
        #1;
        vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL rstwr_wr_en: got %b want 0", wr_en); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL rstwr_frame_done: got %b want 0", frame_done); end
        vectors++; if (rx_ready !== 1'b0) begin miscompares++; $display("FAIL rstwr_ready: got %b want 0", rx_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL rstwr_after_wr_en: got %b want 0", wr_en); end
        vectors++; if (wr_addr !== 3'd0) begin miscompares++; $display("FAIL rstwr_after_addr: got %0d want 0", wr_addr); end
        vectors++; if (wr_data !== 12'h000) begin miscompares++; $display("FAIL rstwr_after_data: got %h want 000", wr_data); end
        vectors++; if (rx_ready !== 1'b1) begin miscompares++; $display("FAIL rstwr_after_ready: got %b want 1", rx_ready); end
        step(1'b0, 8'h00, 1'b0);
        vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL rstwr_late_wr: got %b want 0", wr_en); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_gaps();
        test_frame_wrap();
        test_sync_clear();
        test_reset_in_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
